filter_test_sequencer: RTL and testbench
========================================

# filter_test_sequencer

Stimulus sequencer for the filter test bench top. It drives the `test_overlay`, `test_rate` and `test_delay` controls of the exponential signal generator through a programmed sweep of operating points. It holds each point for a settle interval, then for a capture interval, and flags the capture interval so downstream filter-output checkers and histogrammers sample only settled data. The block sits beside `exp_sig_gen` and replaces the static test pins with a repeatable, self-timed schedule.

## Interface
- `SIZE_DELAY`, default from `package_settings`, is the width of the `test_delay` bus.
- `DELAY_START`, default 0, is the first delay value of each sweep.
- `DELAY_STEP`, default 1, is the delay increment between points. It must be ≥1.
- `DELAY_STOP`, default `2**SIZE_DELAY-1`, is the last allowed delay value, inclusive.
- `SETTLE_CYCLES`, default 256, is the number of cycles per point before capture. It must be ≥1.
- `DWELL_CYCLES`, default 1024, is the number of capture cycles per point. It must be ≥1.

Ports:
- `clk`, input, 1 bit: system clock.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: request to run the sweep. It is sampled only in IDLE.
- `abort`, input, 1 bit: stops a running sweep.
- `combo_mask`, input, 4 bits: enables each {overlay,rate} combination. Bit n enables combo n, where n = {overlay,rate}. The mask is latched on an accepted `start`.
- `test_overlay`, output, 1 bit: overlay control to the generator.
- `test_rate`, output, 1 bit: rate control to the generator.
- `test_delay`, output, `SIZE_DELAY` bits: delay control to the generator.
- `capture_en`, output, 1 bit: high only during DWELL.
- `point_index`, output, 16 bits: index of the current point from sweep start, beginning at 0.
- `busy`, output, 1 bit: high in SETTLE and DWELL.
- `done`, output, 1 bit: single-cycle pulse at normal sweep completion.

## Operation
States: IDLE, SETTLE, DWELL, DONE.

- **Reset value of every output is 0.** Asserting `reset` mid-sweep forces IDLE and zeroes all outputs immediately, without waiting for a clock edge.
- **IDLE:**
  - If `start`=1 and the latched mask ≠0, the block selects the lowest enabled combo, loads `test_delay`=`DELAY_START` and `point_index`=0, and enters SETTLE.
  - If `start`=1 and the mask =0, it goes directly to DONE.
- **SETTLE:** counts `SETTLE_CYCLES` cycles, then enters DWELL.
- **DWELL:** `capture_en`=1 and counts `DWELL_CYCLES` cycles. On the last DWELL cycle the next point is computed:
  - Compute `next = test_delay + DELAY_STEP` at `SIZE_DELAY`+1 bits, with no wrap-around.
  - If `next` ≤ `DELAY_STOP`: `test_delay`←`next`, `point_index`+1, go to SETTLE.
  - Otherwise, if a higher enabled combo exists: switch the overlay/rate outputs to it, set `test_delay`←`DELAY_START`, `point_index`+1, go to SETTLE.
  - Otherwise, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. The control outputs hold their last values until the next `start`.
- **`abort`=1 in SETTLE or DWELL:** next state is IDLE and `done` is not pulsed. `capture_en` and `busy` drop the next cycle, and the control outputs return to 0.
  - `abort` has priority over all state transitions.
  - `abort` in IDLE or DONE is ignored.
- **`start` outside IDLE** is ignored and is not queued.
- **`start` and `abort` both high in IDLE:** `start` wins, because `abort` is ignored in IDLE.
- **Parameter edge case:** if `DELAY_START` > `DELAY_STOP`, each enabled combo still runs exactly one point at `DELAY_START`.
- **`point_index`** saturates at 16'hFFFF.

## Timing
- All outputs are registered.
- Start to outputs: `start` is sampled high at edge k. At edge k+1, `busy`=1 and the control outputs take the first point's values.
- Per point: exactly `SETTLE_CYCLES`+`DWELL_CYCLES` cycles, with no gap between points.
- `capture_en` rises `SETTLE_CYCLES` cycles after the control outputs change. It stays high for exactly `DWELL_CYCLES` cycles.
- Point to point: the control outputs and `point_index` change on the edge where `capture_en` falls and SETTLE begins.
- Completion: `done` is high in the cycle immediately after the last DWELL cycle. `busy` and `done` are never high together.
- Earliest next `start`: IDLE is re-entered the cycle after `done`, and a `start` asserted then is accepted.

## Test plan
- **Single sweep:** `DELAY_START`=2, `DELAY_STEP`=3, `DELAY_STOP`=8, `SETTLE_CYCLES`=4, `DWELL_CYCLES`=8, `combo_mask`=4'b0001.
  - Pulse `start` → `test_delay` goes 2, 5, 8.
  - `busy` is high for 36 cycles and `capture_en` is high for three 8-cycle windows.
  - `done` pulses once at cycle 37; overlay and rate stay 0.
- **Sparse mask:** same parameters, `combo_mask`=4'b1010.
  - Required response: combo 1 (rate=1, overlay=0), then combo 3 (both high), 3 points each.
  - `point_index` runs 0–5 and `done` pulses after 72 busy cycles.
- **Overflow guard:** `SIZE_DELAY`=8, `DELAY_START`=250, `DELAY_STEP`=10, `DELAY_STOP`=255, mask 4'b0001.
  - Required response: exactly one point at delay 250, then `done`, with no wrap to 4.
- **Abort in DWELL:** assert `abort` during the 3rd DWELL cycle of point 1.
  - Next cycle: `busy`=0, `capture_en`=0, all controls 0.
  - `done` never pulses, and a new `start` is accepted.
- **Zero mask:** `start` with mask 0 → `done` at edge k+2, `busy` never high. `start` held high continuously during a sweep → the sweep is not restarted.
- **Async reset:** drop `reset` mid-SETTLE, between clock edges → all outputs go to 0 immediately. After release, the block is in IDLE and accepts `start`.

Source files
------------

// File: rtl/filter_test_sequencer.sv
// Self-timed sweep sequencer for the exp_sig_gen test pins.
// Each enabled {overlay,rate} combo is swept across the delay range, with a settle window then a capture window per point.
module filter_test_sequencer #(
    parameter int unsigned SIZE_DELAY    = 8,
    parameter int unsigned DELAY_START   = 0,
    parameter int unsigned DELAY_STEP    = 1,
    parameter int unsigned DELAY_STOP    = 2**SIZE_DELAY - 1,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned DWELL_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            combo_mask,
    output logic                  test_overlay,
    output logic                  test_rate,
    output logic [SIZE_DELAY-1:0] test_delay,
    output logic                  capture_en,
    output logic [15:0]           point_index,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_t;

    localparam logic [SIZE_DELAY:0]   STEP_EXT    = (SIZE_DELAY+1)'(DELAY_STEP);
    localparam logic [SIZE_DELAY:0]   STOP_EXT    = (SIZE_DELAY+1)'(DELAY_STOP);
    localparam logic [SIZE_DELAY-1:0] START_VAL   = SIZE_DELAY'(DELAY_START);
    localparam logic [31:0]           SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]           DWELL_LOAD  = 32'(DWELL_CYCLES - 1);

    state_t              state;
    logic [3:0]          mask_q;
    logic [31:0]         cnt;
    logic [SIZE_DELAY:0] next_delay;
    logic [1:0]          first_combo;
    logic [1:0]          higher_combo;
    logic                has_higher;
    logic [15:0]         next_index;

    always_comb begin
        next_delay   = {1'b0, test_delay} + STEP_EXT;
        next_index   = (point_index == '1) ? point_index : point_index + 16'd1;
        first_combo  = '0;
        higher_combo = '0;
        has_higher   = 1'b0;
        // Descending scans so the lowest qualifying combo is the one left standing.
        for (int unsigned i = 4; i > 0; i--) begin
            if (combo_mask[i-1])
                first_combo = 2'(i-1);
            if (mask_q[i-1] && (2'(i-1) > {test_overlay, test_rate})) begin
                higher_combo = 2'(i-1);
                has_higher   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mask_q       <= '0;
            cnt          <= '0;
            test_overlay <= 1'b0;
            test_rate    <= 1'b0;
            test_delay   <= '0;
            capture_en   <= 1'b0;
            point_index  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= combo_mask;
                        if (combo_mask != '0) begin
                            state        <= SETTLE;
                            busy         <= 1'b1;
                            test_overlay <= first_combo[1];
                            test_rate    <= first_combo[0];
                            test_delay   <= START_VAL;
                            point_index  <= '0;
                            cnt          <= SETTLE_LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SETTLE, DWELL: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        capture_en   <= 1'b0;
                        test_overlay <= 1'b0;
                        test_rate    <= 1'b0;
                        test_delay   <= '0;
                        point_index  <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else if (state == SETTLE) begin
                        state      <= DWELL;
                        capture_en <= 1'b1;
                        cnt        <= DWELL_LOAD;
                    end else begin
                        capture_en <= 1'b0;
                        if (next_delay <= STOP_EXT) begin
                            state       <= SETTLE;
                            test_delay  <= next_delay[SIZE_DELAY-1:0];
                            point_index <= next_index;
                            cnt         <= SETTLE_LOAD;
                        end else if (has_higher) begin
                            state        <= SETTLE;
                            test_overlay <= higher_combo[1];
                            test_rate    <= higher_combo[0];
                            test_delay   <= START_VAL;
                            point_index  <= next_index;
                            cnt          <= SETTLE_LOAD;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Entered with done low only from the zero-mask path, which pulses one cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Directed bench for filter_test_sequencer: table-driven sweeps plus hand-written abort, reset and edge sequences.
module tb_filter_test_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [3:0]  combo_mask;
    logic        test_overlay, test_rate, capture_en, busy, done;
    logic [7:0]  test_delay;
    logic [15:0] point_index;

    logic        b_start, b_abort;
    logic [3:0]  b_mask;
    logic        b_overlay, b_rate, b_capture, b_busy, b_done;
    logic [7:0]  b_delay;
    logic [15:0] b_index;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    filter_test_sequencer #(
        .SIZE_DELAY(8), .DELAY_START(2), .DELAY_STEP(3), .DELAY_STOP(8),
        .SETTLE_CYCLES(4), .DWELL_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .combo_mask(combo_mask),
        .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
        .capture_en(capture_en), .point_index(point_index), .busy(busy), .done(done)
    );

    filter_test_sequencer #(
        .SIZE_DELAY(8), .DELAY_START(250), .DELAY_STEP(10), .DELAY_STOP(255),
        .SETTLE_CYCLES(4), .DWELL_CYCLES(8)
    ) dut_ovf (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .combo_mask(b_mask),
        .test_overlay(b_overlay), .test_rate(b_rate), .test_delay(b_delay),
        .capture_en(b_capture), .point_index(b_index), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic [3:0]  mask;
        logic        ovl;
        logic        rate;
        logic [7:0]  dly;
        logic [15:0] pidx;
        logic        last;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic ovl, input logic rate,
                            input logic [7:0] dly);
        chk({tag, ".overlay"}, 32'(test_overlay), 32'(ovl));
        chk({tag, ".rate"}, 32'(test_rate), 32'(rate));
        chk({tag, ".delay"}, 32'(test_delay), 32'(dly));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned done_seen;

        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 8'd2, 16'd0, 1'b0};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 8'd5, 16'd1, 1'b0};
        vecs[2]  = '{4'b0001, 1'b0, 1'b0, 8'd8, 16'd2, 1'b1};
        vecs[3]  = '{4'b1010, 1'b0, 1'b1, 8'd2, 16'd0, 1'b0};
        vecs[4]  = '{4'b1010, 1'b0, 1'b1, 8'd5, 16'd1, 1'b0};
        vecs[5]  = '{4'b1010, 1'b0, 1'b1, 8'd8, 16'd2, 1'b0};
        vecs[6]  = '{4'b1010, 1'b1, 1'b1, 8'd2, 16'd3, 1'b0};
        vecs[7]  = '{4'b1010, 1'b1, 1'b1, 8'd5, 16'd4, 1'b0};
        vecs[8]  = '{4'b1010, 1'b1, 1'b1, 8'd8, 16'd5, 1'b1};
        vecs[9]  = '{4'b0100, 1'b1, 1'b0, 8'd2, 16'd0, 1'b0};
        vecs[10] = '{4'b0100, 1'b1, 1'b0, 8'd5, 16'd1, 1'b0};
        vecs[11] = '{4'b0100, 1'b1, 1'b0, 8'd8, 16'd2, 1'b1};

        reset = 1'b0; start = 1'b0; abort = 1'b0; combo_mask = '0;
        b_start = 1'b0; b_abort = 1'b0; b_mask = '0;
        repeat (2) @(negedge clk);
        chk("reset.overlay", 32'(test_overlay), 32'd0);
        chk("reset.rate", 32'(test_rate), 32'd0);
        chk("reset.delay", 32'(test_delay), 32'd0);
        chk("reset.capture", 32'(capture_en), 32'd0);
        chk("reset.index", 32'(point_index), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven sweeps: each point is 4 settle + 8 capture cycles.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pidx == 16'd0) begin
                start = 1'b1; combo_mask = vecs[i].mask;
                @(negedge clk);
                start = 1'b0;
            end
            for (int c = 0; c < 12; c++) begin
                chk_ctrl($sformatf("sweep[%0d].c%0d", i, c), vecs[i].ovl, vecs[i].rate, vecs[i].dly);
                chk($sformatf("sweep[%0d].c%0d.index", i, c), 32'(point_index), 32'(vecs[i].pidx));
                chk($sformatf("sweep[%0d].c%0d.busy", i, c), 32'(busy), 32'd1);
                chk($sformatf("sweep[%0d].c%0d.capture", i, c), 32'(capture_en), (c >= 4) ? 32'd1 : 32'd0);
                chk($sformatf("sweep[%0d].c%0d.done", i, c), 32'(done), 32'd0);
                @(negedge clk);
            end
            if (vecs[i].last) begin
                chk($sformatf("end[%0d].done", i), 32'(done), 32'd1);
                chk($sformatf("end[%0d].busy", i), 32'(busy), 32'd0);
                chk($sformatf("end[%0d].capture", i), 32'(capture_en), 32'd0);
                chk_ctrl($sformatf("end[%0d].hold", i), vecs[i].ovl, vecs[i].rate, vecs[i].dly);
                @(negedge clk);
                chk($sformatf("idle[%0d].done", i), 32'(done), 32'd0);
                chk_ctrl($sformatf("idle[%0d].hold", i), vecs[i].ovl, vecs[i].rate, vecs[i].dly);
            end
        end

        // Overflow guard: 250+10 must not wrap back into range.
        b_start = 1'b1; b_mask = 4'b0001;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("ovf.c%0d.delay", c), 32'(b_delay), 32'd250);
            chk($sformatf("ovf.c%0d.busy", c), 32'(b_busy), 32'd1);
            @(negedge clk);
        end
        chk("ovf.done", 32'(b_done), 32'd1);
        chk("ovf.delay_hold", 32'(b_delay), 32'd250);
        chk("ovf.index", 32'(b_index), 32'd0);
        @(negedge clk);
        chk("ovf.done_clear", 32'(b_done), 32'd0);

        // Abort in the 3rd DWELL cycle of point 1 (cycle 18 of the sweep).
        start = 1'b1; combo_mask = 4'b1010;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        chk("abort.pre.capture", 32'(capture_en), 32'd1);
        chk_ctrl("abort.pre", 1'b0, 1'b1, 8'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.capture", 32'(capture_en), 32'd0);
        chk_ctrl("abort.ctrl", 1'b0, 1'b0, 8'd0);
        done_seen = 0;
        repeat (30) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("abort.no_done", done_seen, 32'd0);
        start = 1'b1; combo_mask = 4'b0001;
        @(negedge clk);
        start = 1'b0;
        chk("abort.restart.busy", 32'(busy), 32'd1);
        chk("abort.restart.delay", 32'(test_delay), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_settle.busy", 32'(busy), 32'd0);

        // Start and abort together in IDLE: start wins.
        start = 1'b1; abort = 1'b1; combo_mask = 4'b0001;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort.busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Zero mask: done two edges after start, busy never high, earliest restart accepted.
        start = 1'b1; combo_mask = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        chk("zero.k1.done", 32'(done), 32'd0);
        chk("zero.k1.busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("zero.k2.done", 32'(done), 32'd1);
        chk("zero.k2.busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("zero.k3.done", 32'(done), 32'd0);
        start = 1'b1; combo_mask = 4'b0001;
        @(negedge clk);
        chk("early_start.busy", 32'(busy), 32'd1);
        chk("early_start.delay", 32'(test_delay), 32'd2);

        // Start held high throughout: no restart mid-sweep.
        repeat (20) @(negedge clk);
        chk("hold_start.index", 32'(point_index), 32'd1);
        chk("hold_start.delay", 32'(test_delay), 32'd5);
        chk("hold_start.busy", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (16) @(negedge clk);
        chk("hold_start.done", 32'(done), 32'd1);
        @(negedge clk);

        // Async reset between edges, mid-SETTLE.
        start = 1'b1; combo_mask = 4'b1000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("areset.pre.busy", 32'(busy), 32'd1);
        chk("areset.pre.overlay", 32'(test_overlay), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset.busy", 32'(busy), 32'd0);
        chk_ctrl("areset", 1'b0, 1'b0, 8'd0);
        chk("areset.capture", 32'(capture_en), 32'd0);
        chk("areset.done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1; combo_mask = 4'b0100;
        @(negedge clk);
        start = 1'b0;
        chk("areset.restart.busy", 32'(busy), 32'd1);
        chk_ctrl("areset.restart", 1'b1, 1'b0, 8'd2);
        chk("areset.restart.index", 32'(point_index), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
